inst_dispatcher: RTL and testbench

Consumes the instruction stream of the AXI instruction receiver (instruction / instruction_id / instruction_valid / instruction_next) and decodes each 64-bit word. Issues it to one of NUM_UNITS execution units over valid/ready and tracks outstanding ids in a scoreboard. Arbitrates unit results round-robin back into the receiver's data / data_id / data_valid writeback port.

---
 rtl/inst_dispatch_pkg.sv | 20 ++
 rtl/rr_arbiter.sv | 45 ++++
 rtl/inst_dispatcher.sv | 226 ++++++++++++++++++++++
 tb/tb_inst_dispatcher.sv | 352 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/inst_dispatch_pkg.sv
// Shared decode constants and FSM state type for the instruction dispatcher.
package inst_dispatch_pkg;

    localparam int unsigned OP_MSB = 63;
    localparam int unsigned OP_LSB = 56;

    localparam logic [7:0] OP_NOP   = 8'h00;
    localparam logic [7:0] OP_FENCE = 8'hFF;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        FENCE_WAIT
    } state_e;

    function automatic logic is_internal_op(input logic [7:0] op);
        return (op == OP_NOP) || (op == OP_FENCE);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant searched from the pointer, pointer moves past each grant.
module rr_arbiter #(
    parameter int unsigned N = 4,
    localparam int unsigned W = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req_i,
    input  logic         en_i,
    output logic [N-1:0] gnt_o,
    output logic [W-1:0] gnt_idx_o,
    output logic         gnt_valid_o
);

    logic [W-1:0] ptr_q, ptr_d;
    logic [W-1:0] idx;

    always_comb begin
        gnt_o       = '0;
        gnt_idx_o   = '0;
        gnt_valid_o = 1'b0;
        idx         = '0;
        // N is a power of two, so W-bit addition wraps the search naturally.
        for (int k = 0; k < N; k++) begin
            idx = ptr_q + W'(k);
            if (en_i && !gnt_valid_o && req_i[idx]) begin
                gnt_valid_o = 1'b1;
                gnt_idx_o   = idx;
            end
        end
        if (gnt_valid_o) begin
            gnt_o[gnt_idx_o] = 1'b1;
        end
        ptr_d = gnt_valid_o ? gnt_idx_o + W'(1) : ptr_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/inst_dispatcher.sv
// Decodes receiver words, issues them to execution units and writes results back.
// Define DISPATCH_PERF_COUNTERS_EN to add issue/retire/stall performance counters.
module inst_dispatcher
    import inst_dispatch_pkg::*;
#(
    parameter int unsigned DATA_WIDTH        = 64,
    parameter int unsigned INSTRUCTION_DEPTH = 16,
    parameter int unsigned NUM_UNITS         = 4,
    parameter int unsigned MAX_OUTSTANDING   = 8,
    localparam int unsigned ID_W = $clog2(INSTRUCTION_DEPTH),
    localparam int unsigned U_W  = $clog2(NUM_UNITS)
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [DATA_WIDTH-1:0]           instruction,
    input  logic [ID_W-1:0]                 instruction_id,
    input  logic                            instruction_valid,
    output logic                            instruction_next,
    output logic [DATA_WIDTH-1:0]           data,
    output logic [ID_W-1:0]                 data_id,
    output logic                            data_valid,
    output logic [NUM_UNITS-1:0]            unit_valid,
    output logic [DATA_WIDTH-1:0]           unit_inst,
    output logic [ID_W-1:0]                 unit_id,
    input  logic [NUM_UNITS-1:0]            unit_ready,
    input  logic [NUM_UNITS-1:0]            res_valid,
    input  logic [NUM_UNITS*ID_W-1:0]       res_id,
    input  logic [NUM_UNITS*DATA_WIDTH-1:0] res_data,
    output logic [NUM_UNITS-1:0]            res_ready,
    output logic                            busy,
    output logic                            err_unexpected
`ifdef DISPATCH_PERF_COUNTERS_EN
    ,
    output logic [31:0]                     perf_issued,
    output logic [31:0]                     perf_retired,
    output logic [31:0]                     perf_stall_cycles
`endif
);

    localparam int unsigned OW = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [OW-1:0] MaxOut = OW'(MAX_OUTSTANDING);

    state_e                 state_q, state_d;
    logic [DATA_WIDTH-1:0]  inst_q, inst_d;
    logic [ID_W-1:0]        id_q, id_d;
    logic [OW-1:0]          outstanding_q, outstanding_d;
    logic [INSTRUCTION_DEPTH-1:0] sb_q, sb_d;
    logic [DATA_WIDTH-1:0]  data_q, data_d;
    logic [ID_W-1:0]        data_id_q, data_id_d;
    logic                   data_valid_q, data_valid_d;
    logic                   err_q, err_d;

    logic [7:0]             opcode;
    logic                   in_nop, in_fence, accept, issue_hs, retire;
    logic                   cpl_valid, arb_en;
    logic [ID_W-1:0]        cpl_id;
    logic [U_W-1:0]         unit_sel;
    logic [U_W-1:0]         gnt_idx;
    logic                   gnt_valid;
    logic [ID_W-1:0]        g_id;
    logic [DATA_WIDTH-1:0]  g_data;

    assign opcode   = instruction[OP_MSB:OP_LSB];
    assign in_nop   = (opcode == OP_NOP);
    assign in_fence = (opcode == OP_FENCE);
    assign unit_sel = inst_q[OP_LSB +: U_W];

    // Completions enter the writeback register in the cycle they form, so none is ever left
    // pending; that is why no pending term appears in the accept or fence conditions.
    assign accept = rst_n && (state_q == IDLE) && instruction_valid &&
                    (is_internal_op(opcode) || (outstanding_q < MaxOut));
    assign instruction_next = accept;

    assign issue_hs  = (state_q == ISSUE) && unit_ready[unit_sel];
    assign cpl_valid = (accept && in_nop) || ((state_q == FENCE_WAIT) && (outstanding_q == '0));
    assign cpl_id    = (state_q == FENCE_WAIT) ? id_q : instruction_id;
    assign arb_en    = rst_n && !cpl_valid;

    rr_arbiter #(
        .N(NUM_UNITS)
    ) u_arb (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_i       (res_valid),
        .en_i        (arb_en),
        .gnt_o       (res_ready),
        .gnt_idx_o   (gnt_idx),
        .gnt_valid_o (gnt_valid)
    );

    assign g_id   = res_id[gnt_idx*ID_W +: ID_W];
    assign g_data = res_data[gnt_idx*DATA_WIDTH +: DATA_WIDTH];

    always_comb begin
        state_d       = state_q;
        inst_d        = inst_q;
        id_d          = id_q;
        sb_d          = sb_q;
        outstanding_d = outstanding_q;
        data_d        = data_q;
        data_id_d     = data_id_q;
        data_valid_d  = 1'b0;
        err_d         = err_q;
        retire        = 1'b0;

        // Internal completions take the writeback slot ahead of any unit result.
        if (cpl_valid) begin
            data_valid_d = 1'b1;
            data_d       = '0;
            data_id_d    = cpl_id;
        end else if (gnt_valid) begin
            if (sb_q[g_id] && (outstanding_q != '0)) begin
                data_valid_d = 1'b1;
                data_d       = g_data;
                data_id_d    = g_id;
                sb_d[g_id]   = 1'b0;
                retire       = 1'b1;
            end else begin
                err_d = 1'b1;
            end
        end

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    inst_d = instruction;
                    id_d   = instruction_id;
                    if (in_fence) begin
                        state_d = FENCE_WAIT;
                    end else if (!in_nop) begin
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: begin
                if (issue_hs) begin
                    sb_d[id_q] = 1'b1;
                    state_d    = IDLE;
                end
            end
            FENCE_WAIT: begin
                if (outstanding_q == '0) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        unique case ({issue_hs, retire})
            2'b10:   outstanding_d = outstanding_q + OW'(1);
            2'b01:   outstanding_d = outstanding_q - OW'(1);
            default: outstanding_d = outstanding_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            inst_q        <= '0;
            id_q          <= '0;
            outstanding_q <= '0;
            sb_q          <= '0;
            data_q        <= '0;
            data_id_q     <= '0;
            data_valid_q  <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            inst_q        <= inst_d;
            id_q          <= id_d;
            outstanding_q <= outstanding_d;
            sb_q          <= sb_d;
            data_q        <= data_d;
            data_id_q     <= data_id_d;
            data_valid_q  <= data_valid_d;
            err_q         <= err_d;
        end
    end

    always_comb begin
        unit_valid = '0;
        if (state_q == ISSUE) begin
            unit_valid[unit_sel] = 1'b1;
        end
    end

    assign unit_inst      = inst_q;
    assign unit_id        = id_q;
    assign data           = data_q;
    assign data_id        = data_id_q;
    assign data_valid     = data_valid_q;
    assign err_unexpected = err_q;
    assign busy           = (state_q != IDLE) || (outstanding_q != '0);

`ifdef DISPATCH_PERF_COUNTERS_EN
    logic [31:0] perf_issued_q, perf_issued_d;
    logic [31:0] perf_retired_q, perf_retired_d;
    logic [31:0] perf_stall_q, perf_stall_d;
    logic        stall;

    assign stall = rst_n && (state_q == IDLE) && instruction_valid && !accept;

    always_comb begin
        perf_issued_d  = perf_issued_q + (issue_hs ? 32'd1 : 32'd0);
        perf_retired_d = perf_retired_q + (retire ? 32'd1 : 32'd0);
        perf_stall_d   = perf_stall_q + (stall ? 32'd1 : 32'd0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_issued_q  <= '0;
            perf_retired_q <= '0;
            perf_stall_q   <= '0;
        end else begin
            perf_issued_q  <= perf_issued_d;
            perf_retired_q <= perf_retired_d;
            perf_stall_q   <= perf_stall_d;
        end
    end

    assign perf_issued       = perf_issued_q;
    assign perf_retired      = perf_retired_q;
    assign perf_stall_cycles = perf_stall_q;
`endif

endmodule

// File: tb/tb_inst_dispatcher.sv
// Directed bench for inst_dispatcher with a transaction-level reference model checked each cycle.
module tb_inst_dispatcher;

    localparam int NU   = 4;
    localparam int MAXO = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic [63:0]      instruction;
    logic [3:0]       instruction_id;
    logic             instruction_valid;
    logic             instruction_next;
    logic [63:0]      data;
    logic [3:0]       data_id;
    logic             data_valid;
    logic [NU-1:0]    unit_valid;
    logic [63:0]      unit_inst;
    logic [3:0]       unit_id;
    logic [NU-1:0]    unit_ready;
    logic [NU-1:0]    res_valid;
    logic [NU*4-1:0]  res_id;
    logic [NU*64-1:0] res_data;
    logic [NU-1:0]    res_ready;
    logic             busy;
    logic             err_unexpected;
`ifdef DISPATCH_PERF_COUNTERS_EN
    logic [31:0]      perf_issued, perf_retired, perf_stall_cycles;
`endif

    inst_dispatcher #(
        .DATA_WIDTH(64), .INSTRUCTION_DEPTH(16), .NUM_UNITS(NU), .MAX_OUTSTANDING(MAXO)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .instruction(instruction), .instruction_id(instruction_id),
        .instruction_valid(instruction_valid), .instruction_next(instruction_next),
        .data(data), .data_id(data_id), .data_valid(data_valid),
        .unit_valid(unit_valid), .unit_inst(unit_inst), .unit_id(unit_id),
        .unit_ready(unit_ready),
        .res_valid(res_valid), .res_id(res_id), .res_data(res_data), .res_ready(res_ready),
        .busy(busy), .err_unexpected(err_unexpected)
`ifdef DISPATCH_PERF_COUNTERS_EN
        , .perf_issued(perf_issued), .perf_retired(perf_retired),
        .perf_stall_cycles(perf_stall_cycles)
`endif
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Receiver word queue and per-unit result slots driven by the bench.
    logic [63:0] rxq_w[$];
    logic [3:0]  rxq_id[$];
    logic        sv[NU];
    logic [3:0]  sid[NU];
    logic [63:0] sdat[NU];
    logic        s_next;
    logic [NU-1:0] s_rr;

    task automatic apply();
        instruction_valid = (rxq_w.size() > 0);
        instruction       = (rxq_w.size() > 0) ? rxq_w[0] : 64'h0;
        instruction_id    = (rxq_id.size() > 0) ? rxq_id[0] : 4'h0;
        for (int u = 0; u < NU; u++) begin
            res_valid[u]       = sv[u];
            res_id[u*4 +: 4]   = sid[u];
            res_data[u*64 +: 64] = sdat[u];
        end
    endtask

    task automatic push(input logic [7:0] op, input logic [3:0] id);
        rxq_w.push_back({op, 24'hC0FFEE, 28'h0, id});
        rxq_id.push_back(id);
        apply();
    endtask

    task automatic give(input int u, input logic [3:0] id, input logic [63:0] d);
        sv[u] = 1'b1; sid[u] = id; sdat[u] = d;
        apply();
    endtask

    task automatic step();
        @(posedge clk);
        if (s_next && rxq_w.size() > 0) begin
            void'(rxq_w.pop_front());
            void'(rxq_id.pop_front());
        end
        for (int u = 0; u < NU; u++) if (s_rr[u]) sv[u] = 1'b0;
        #1 apply();
    endtask

    // Reference model: mode 0 idle, 1 issuing, 2 fence; outstanding = ids in the set.
    int          m_mode;
    logic [63:0] m_inst;
    logic [3:0]  m_id;
    logic [15:0] m_sb;
    int          m_rr;
    logic        m_err;
    logic        m_dv;
    logic [3:0]  m_did;
    logic [63:0] m_dat;
    int          m_iss, m_ret, m_stall;
    logic        e_next, e_cpl;
    int          e_g, e_cnt, cu;
    logic [3:0]  e_uv, e_rr;
    logic [7:0]  cop;

    always @(negedge clk) begin
        cop    = instruction[63:56];
        e_cnt  = $countones(m_sb);
        e_next = rst_n && (m_mode == 0) && instruction_valid &&
                 (cop == 8'h00 || cop == 8'hFF || e_cnt < MAXO);
        e_uv   = (m_mode == 1) ? (4'b0001 << m_inst[57:56]) : 4'b0000;
        e_cpl  = ((m_mode == 0) && e_next && cop == 8'h00) || ((m_mode == 2) && e_cnt == 0);
        e_g    = -1;
        if (rst_n && !e_cpl) begin
            for (int k = 0; k < NU; k++) begin
                cu = (m_rr + k) % NU;
                if (e_g < 0 && res_valid[cu]) e_g = cu;
            end
        end
        e_rr   = (e_g >= 0) ? (4'b0001 << e_g) : 4'b0000;
        s_next = instruction_next;
        s_rr   = res_ready;

        chk("m_next", instruction_next, e_next);
        chk("m_unit_valid", unit_valid, e_uv);
        if (m_mode == 1) begin
            chk("m_unit_inst", unit_inst, m_inst);
            chk("m_unit_id", unit_id, m_id);
        end
        chk("m_res_ready", res_ready, e_rr);
        chk("m_data_valid", data_valid, m_dv);
        if (m_dv) begin
            chk("m_data", data, m_dat);
            chk("m_data_id", data_id, m_did);
        end
        chk("m_busy", busy, (m_mode != 0) || (e_cnt != 0));
        chk("m_err", err_unexpected, m_err);
`ifdef DISPATCH_PERF_COUNTERS_EN
        chk("m_perf_issued", perf_issued, m_iss);
        chk("m_perf_retired", perf_retired, m_ret);
        chk("m_perf_stall", perf_stall_cycles, m_stall);
`endif
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_mode <= 0; m_inst <= '0; m_id <= '0; m_sb <= '0; m_rr <= 0; m_err <= 1'b0;
            m_dv <= 1'b0; m_did <= '0; m_dat <= '0; m_iss <= 0; m_ret <= 0; m_stall <= 0;
        end else begin
            m_dv <= 1'b0;
            if (e_cpl) begin
                m_dv  <= 1'b1;
                m_dat <= '0;
                m_did <= (m_mode == 2) ? m_id : instruction_id;
            end else if (e_g >= 0) begin
                m_rr <= (e_g + 1) % NU;
                if (m_sb[res_id[e_g*4 +: 4]]) begin
                    m_dv  <= 1'b1;
                    m_dat <= res_data[e_g*64 +: 64];
                    m_did <= res_id[e_g*4 +: 4];
                    m_sb[res_id[e_g*4 +: 4]] <= 1'b0;
                    m_ret <= m_ret + 1;
                end else begin
                    m_err <= 1'b1;
                end
            end
            if (m_mode == 1 && unit_ready[m_inst[57:56]]) begin
                m_sb[m_id] <= 1'b1;
                m_mode     <= 0;
                m_iss      <= m_iss + 1;
            end else if (m_mode == 0 && e_next) begin
                m_inst <= instruction;
                m_id   <= instruction_id;
                m_mode <= (instruction[63:56] == 8'h00) ? 0 :
                          (instruction[63:56] == 8'hFF) ? 2 : 1;
            end else if (m_mode == 2 && e_cnt == 0) begin
                m_mode <= 0;
            end
            if (m_mode == 0 && instruction_valid && !e_next) m_stall <= m_stall + 1;
        end
    end

`ifdef DISPATCH_PERF_COUNTERS_EN
    logic [31:0] stall0;
`endif

    initial begin
        instruction = '0; instruction_id = '0; instruction_valid = 1'b0;
        unit_ready = '0; res_valid = '0; res_id = '0; res_data = '0;
        s_next = 1'b0; s_rr = '0;
        for (int u = 0; u < NU; u++) begin sv[u] = 1'b0; sid[u] = '0; sdat[u] = '0; end
        #1 rst_n = 1'b0;
        #2;
        chk("rst_next", instruction_next, 0);
        chk("rst_unit_valid", unit_valid, 0);
        chk("rst_data_valid", data_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", err_unexpected, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Single op to unit 1, ready withheld for four cycles.
        push(8'h01, 4'd3);
        #1 chk("s1_next", instruction_next, 1);
        step();
        for (int i = 0; i < 4; i++) begin
            #1 chk("s1_hold_uv", unit_valid, 4'b0010);
            chk("s1_hold_id", unit_id, 3);
            step();
        end
        unit_ready = 4'b0010;
        #1 chk("s1_issue_uv", unit_valid, 4'b0010);
        step();
        unit_ready = 4'b0000;
        #1 chk("s1_busy", busy, 1);
        chk("s1_uv_clear", unit_valid, 0);
        give(1, 4'd3, 64'hABCD);
        #1 chk("s1_res_ready", res_ready, 4'b0010);
        step();
        #1 chk("s1_dv", data_valid, 1);
        chk("s1_did", data_id, 3);
        chk("s1_data", data, 64'hABCD);
        chk("s1_idle", busy, 0);
        step();

        // NOP: writeback one cycle after acceptance, no issue.
        push(8'h00, 4'd5);
        #1 chk("s2_next", instruction_next, 1);
        step();
        #1 chk("s2_dv", data_valid, 1);
        chk("s2_did", data_id, 5);
        chk("s2_data", data, 0);
        chk("s2_uv", unit_valid, 0);
        step();

        // Fill to the outstanding cap; ninth word must wait for a retire.
        unit_ready = 4'b1111;
        for (int k = 0; k < 8; k++) push(8'h10 | 8'(k % 4), 4'(k));
        push(8'h11, 4'd8);
        repeat (16) step();
        #1 chk("s3_cap_next", instruction_next, 0);
        chk("s3_cap_busy", busy, 1);
`ifdef DISPATCH_PERF_COUNTERS_EN
        stall0 = perf_stall_cycles;
`endif
        step();
        #1 chk("s3_cap_next2", instruction_next, 0);
`ifdef DISPATCH_PERF_COUNTERS_EN
        chk("s3_stall_inc", perf_stall_cycles - stall0, 1);
`endif
        give(3, 4'd3, 64'h33);
        #1 chk("s3_rr", res_ready, 4'b1000);
        step();
        #1 chk("s3_ret_dv", data_id, 3);
        chk("s3_resume_next", instruction_next, 1);
        step();
        #1 chk("s3_ninth_uv", unit_valid, 4'b0010);
        chk("s3_ninth_id", unit_id, 8);
        step();

        // Four simultaneous results with a NOP injected in the middle.
        give(0, 4'd0, 64'hA0); give(1, 4'd1, 64'hA1);
        give(2, 4'd2, 64'hA2); give(3, 4'd7, 64'hA7);
        #1 chk("s4_g0", res_ready, 4'b0001);
        step();
        #1 chk("s4_g1", res_ready, 4'b0010);
        chk("s4_d0", data, 64'hA0);
        step();
        push(8'h00, 4'd9);
        #1 chk("s4_nop_wins", res_ready, 4'b0000);
        chk("s4_d1", data_id, 1);
        step();
        #1 chk("s4_g2", res_ready, 4'b0100);
        chk("s4_nop_did", data_id, 9);
        step();
        #1 chk("s4_g3", res_ready, 4'b1000);
        chk("s4_d2", data_id, 2);
        step();
        #1 chk("s4_d7", data_id, 7);
        step();

        // Fence behind two outstanding ops (ids 6 and 8).
        give(0, 4'd4, 64'hB4); give(1, 4'd5, 64'hB5);
        step(); step();
        push(8'hFF, 4'd10);
        push(8'h12, 4'd11);
        #1 chk("s5_fence_next", instruction_next, 1);
        for (int i = 0; i < 3; i++) begin
            step();
            #1 chk("s5_wait_dv", data_valid, 0);
            chk("s5_wait_next", instruction_next, 0);
        end
        give(2, 4'd6, 64'hB6);
        step();
        #1 chk("s5_d6", data_id, 6);
        chk("s5_held", instruction_next, 0);
        step();
        give(1, 4'd8, 64'hB8);
        step();
        #1 chk("s5_d8", data_id, 8);
        chk("s5_held2", instruction_next, 0);
        step();
        #1 chk("s5_fence_dv", data_valid, 1);
        chk("s5_fence_did", data_id, 10);
        chk("s5_after_next", instruction_next, 1);
        step();
        #1 chk("s5_op11_uv", unit_valid, 4'b0100);
        step();

        // Unexpected result id, then reset in the middle of an issue.
        give(3, 4'd7, 64'hDEAD);
        #1 chk("s6_rr", res_ready, 4'b1000);
        step();
        #1 chk("s6_no_dv", data_valid, 0);
        chk("s6_err", err_unexpected, 1);
        unit_ready = 4'b0000;
        push(8'h13, 4'd12);
        step();
        #1 chk("s6_issue_uv", unit_valid, 4'b1000);
        rst_n = 1'b0;
        #1 chk("s6_rst_uv", unit_valid, 0);
        chk("s6_rst_next", instruction_next, 0);
        chk("s6_rst_rr", res_ready, 0);
        chk("s6_rst_err", err_unexpected, 0);
        chk("s6_rst_busy", busy, 0);
        chk("s6_rst_inst", unit_inst, 0);
        chk("s6_rst_id", unit_id, 0);
        chk("s6_rst_dv", data_valid, 0);
        rxq_w.delete();
        rxq_id.delete();
        for (int u = 0; u < NU; u++) sv[u] = 1'b0;
        apply();
        step(); step();
        rst_n = 1'b1;
        step(); step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
